// File: rtl/banco_reg_multi.sv
// Register bank with a built-in clear sequencer and NUM_RD combinational read ports.
// Latency: writes take effect on the next clk edge; reads are combinational (0 cycles).
// Backpressure: none; o_busy=1 while clearing, writes are ignored and reads return 0.
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     synchronous reset, active low; restarts the clear sequence
//   i_clr_req   pulse in RUN: rerun the clear sequence (same-cycle write dropped)
//   i_wr_en     write strobe
//   i_wr_addr   write address
//   i_wr_data   write data
//   i_rd_addr   packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   o_rd_data   packed read data,     port k = [k*DATA_W +: DATA_W]
//   o_busy      1 while the clear sequence runs
//   o_clr_done  one-cycle pulse on the last clear cycle
module banco_reg_multi #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr_req,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic                       o_busy,
  output logic                       o_clr_done
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic                w_we;
  logic [ADDR_W-1:0]   w_we_addr;
  logic [DATA_W-1:0]   w_we_data;
  logic [DATA_W-1:0]   r_bank [DEPTH];

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state, array write port selection and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    o_busy      = 1'b0;
    o_clr_done  = 1'b0;
    w_we        = 1'b0;
    w_we_addr   = i_wr_addr;
    w_we_data   = i_wr_data;
    case (r_state)
      ST_CLEAR: begin
        // Sequencer owns the write port; user writes and clr_req are ignored.
        o_busy    = 1'b1;
        w_we      = 1'b1;
        w_we_addr = r_ptr;
        w_we_data = '0;
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == LAST_ADDR) begin
          o_clr_done  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_clr_req) begin
          // Clear wins over a write in the same cycle.
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end else if (i_wr_en && !((ZERO_REG != 0) && (i_wr_addr == '0))) begin
          w_we = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Storage: no reset on the array itself, the clear sequence zeroes it.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_we) begin
      r_bank[w_we_addr] <= w_we_data;
    end
  end

  // Read ports
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_dat;

    assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_dat = r_bank[w_addr];
      if (r_state == ST_CLEAR) begin
        w_dat = '0;
      end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_dat = '0;
      end else if ((BYPASS != 0) && i_wr_en && (i_wr_addr == w_addr)) begin
        w_dat = i_wr_data;
      end
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = w_dat;
  end

endmodule

// File: tb/tb_banco_reg_multi.sv
module tb_banco_reg_multi;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk;
  logic             rst_n;
  logic             clr_req;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             busy;
  logic             clr_done;
  logic [NR*DW-1:0] rd_data_nb;
  logic             busy_nb;
  logic             clr_done_nb;

  banco_reg_multi #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_busy(busy), .o_clr_done(clr_done)
  );

  banco_reg_multi #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data_nb), .o_busy(busy_nb), .o_clr_done(clr_done_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kinds: 0 rd0, 1 rd1, 2 busy, 3 clr_done, 4 nb rd0, 5 nb rd1, 6 nb busy, 7 nb clr_done
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: every cycle the outputs are presented, compare all queued expectations
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = rd_data[31:0];
        1:       act = rd_data[63:32];
        2:       act = {31'd0, busy};
        3:       act = {31'd0, clr_done};
        4:       act = rd_data_nb[31:0];
        5:       act = rd_data_nb[63:32];
        6:       act = {31'd0, busy_nb};
        default: act = {31'd0, clr_done_nb};
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Runs a full clear window: 32 cycles busy, clr_done only on the last
  task automatic clear_window(input string tag, input int clr_pulse_at);
    for (int i = 0; i < 32; i++) begin
      clr_req = (i == clr_pulse_at);
      expect_val(2, 32'd1, {tag, "_busy"});
      expect_val(3, (i == 31) ? 32'd1 : 32'd0, {tag, "_clr_done"});
      expect_val(0, 32'd0, {tag, "_rd0_busy"});
      tick();
    end
    clr_req = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    clr_req = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;

    // T1: reset for 2 clocks, then full clear
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      expect_val(2, 32'd1, "t1_busy");
      expect_val(3, (i == 31) ? 32'd1 : 32'd0, "t1_clr_done");
      expect_val(6, 32'd1, "t1_nb_busy");
      expect_val(7, (i == 31) ? 32'd1 : 32'd0, "t1_nb_clr_done");
      tick();
    end
    expect_val(2, 32'd0, "t1_busy_after");
    expect_val(3, 32'd0, "t1_clr_done_after");
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), AW'(31 - a));
      expect_val(0, 32'd0, "t1_clear_rd0");
      expect_val(1, 32'd0, "t1_clear_rd1");
      expect_val(4, 32'd0, "t1_clear_nb_rd0");
      tick();
    end

    // T2: write r5 and r31, read back on both ports
    wr_en = 1'b1; wr_addr = 5'd5;  wr_data = 32'hDEADBEEF; tick();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h12345678; tick();
    wr_en = 1'b0;
    set_rd(5'd5, 5'd31);
    expect_val(0, 32'hDEADBEEF, "t2_r5");
    expect_val(1, 32'h12345678, "t2_r31");
    expect_val(5, 32'h12345678, "t2_nb_r31");
    tick();

    // T3: write to r0 is dropped, reads of r0 are zero
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0);
    expect_val(0, 32'd0, "t3_r0_same_rd0");
    expect_val(1, 32'd0, "t3_r0_same_rd1");
    tick();
    wr_en = 1'b0;
    expect_val(0, 32'd0, "t3_r0_after_rd0");
    expect_val(1, 32'd0, "t3_r0_after_rd1");
    tick();

    // T4: bypass vs. no-bypass on r7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111; tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    set_rd(5'd7, 5'd5);
    expect_val(0, 32'hA5A5A5A5, "t4_bypass_same");
    expect_val(4, 32'h11111111, "t4_nb_old");
    expect_val(1, 32'hDEADBEEF, "t4_rd1_r5");
    tick();
    wr_en = 1'b0;
    expect_val(0, 32'hA5A5A5A5, "t4_after");
    expect_val(4, 32'hA5A5A5A5, "t4_nb_after");
    tick();

    // T5: clr_req with a same-cycle write
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; tick();
    set_rd(5'd3, 5'd4);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h66;
    expect_val(2, 32'd0, "t5_busy_req_cycle");
    expect_val(0, 32'h55, "t5_r3_before");
    tick();
    clr_req = 1'b0; wr_en = 1'b0;
    clear_window("t5", -1);
    expect_val(2, 32'd0, "t5_busy_after");
    expect_val(0, 32'd0, "t5_r3_cleared");
    expect_val(1, 32'd0, "t5_r4_cleared");
    tick();

    // T6: reset at clear cycle 10 restarts; writes and clr_req during busy ignored
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; tick();
    wr_en = 1'b0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_val(2, 32'd1, "t6_busy_pre");
      tick();
    end
    rst_n = 1'b0;
    expect_val(2, 32'd1, "t6_busy_rst");
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h00000BAD;
    clear_window("t6", 5);
    wr_en = 1'b0;
    set_rd(5'd12, 5'd9);
    expect_val(2, 32'd0, "t6_busy_after");
    expect_val(0, 32'd0, "t6_r12_not_written");
    expect_val(1, 32'd0, "t6_r9_cleared");
    tick();
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h1234; tick();
    wr_en = 1'b0;
    expect_val(0, 32'h1234, "t6_r12_write_after");
    expect_val(4, 32'h1234, "t6_nb_r12_write_after");
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
